// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests,
// an in-order response FIFO toward decode, and redirect flushing.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding, count, discard, out_net;
    logic [PW-1:0] head, tail, tag_head, tag_tail;
    logic [31:0]   instr_q [FIFO_DEPTH];
    logic [31:0]   pc_q    [FIFO_DEPTH];
    logic [31:0]   tag_q   [FIFO_DEPTH];
    logic          fire, resp, drop, wr, pop;

    always_comb begin
        // Credit: every accepted request is guaranteed a FIFO slot on return.
        imem_req_valid = !rst && !redirect_valid &&
                         (({1'b0, outstanding} + {1'b0, count}) < DEPTH);
        imem_req_addr  = pc;
        id_valid       = !rst && (count != '0) && !redirect_valid;
        id_instr       = (count != '0) ? instr_q[head] : '0;
        id_pc          = (count != '0) ? pc_q[head]    : '0;
        fire           = imem_req_valid && imem_req_ready;
        // Responses with nothing outstanding (e.g. survivors of a reset) are ignored.
        resp           = imem_resp_valid && (outstanding != '0);
        drop           = resp && (discard != '0);
        wr             = resp && !drop && !redirect_valid;
        pop            = id_valid && id_ready;
        out_net        = outstanding - CW'(resp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            count       <= '0;
            discard     <= '0;
            head        <= '0;
            tail        <= '0;
            tag_head    <= '0;
            tag_tail    <= '0;
        end else if (redirect_valid) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            tag_head    <= '0;
            tag_tail    <= '0;
            // Everything still in flight is now stale but still occupies credit.
            discard     <= out_net;
            outstanding <= out_net;
        end else begin
            if (fire) begin
                pc             <= pc + 32'd4;
                tag_q[tag_tail] <= pc;
                tag_tail       <= tag_tail + PW'(1);
            end
            if (wr) begin
                instr_q[tail] <= imem_resp_data;
                pc_q[tail]    <= tag_q[tag_head];
                tail          <= tail + PW'(1);
                tag_head      <= tag_head + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            outstanding <= outstanding + CW'(fire) - CW'(resp);
            discard     <= discard - CW'(drop);
            count       <= count + CW'(wr) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with variable
// latency and a reference stream model (sequential PCs from the last target).
module tb_fetch_unit;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, id_instr, id_pc;
    logic        redirect_valid, id_valid, id_ready;

    logic        w_req_valid, w_id_valid;
    logic [31:0] w_req_addr, w_id_instr, w_id_pc;
    logic        w_resp_valid = 1'b0;
    logic [31:0] w_resp_data = '0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc)
    );

    // Second instance for PC wrap: always-ready memory with 1-cycle latency.
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr), .imem_resp_valid(w_resp_valid),
        .imem_resp_data(w_resp_data), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .id_valid(w_id_valid), .id_ready(1'b1),
        .id_instr(w_id_instr), .id_pc(w_id_pc)
    );

    always @(posedge clk) begin
        w_resp_valid <= w_req_valid && !rst;
        w_resp_data  <= w_req_addr ^ K;
    end

    int checks = 0, errors = 0;
    int cycle = 0, lat = 1, last_due = 0;
    int n_fire = 0, n_pop = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_pc, exp_req;
    bit          s_req_valid, s_id_valid, s_fire, s_pop;
    logic [31:0] s_id_pc;
    bit          auto_redir = 0, redir_hit = 0;
    logic [31:0] auto_tgt;

    // One clock cycle: drive at negedge, sample 1ns later, update model at posedge.
    task automatic step(input bit r, input bit rdy, input bit drdy,
                        input bit redir, input logic [31:0] tgt);
        bit fire, pop, rv;
        int d;
        rst = r; imem_req_ready = rdy; id_ready = drdy;
        redirect_valid = redir; redirect_pc = tgt;
        rv = (mq_addr.size() > 0) && (mq_due[0] <= cycle);
        imem_resp_valid = rv;
        imem_resp_data  = rv ? (mq_addr[0] ^ K) : $urandom;
        #1;
        if (auto_redir && !r && !redir && id_valid && rv && drdy) begin
            redir = 1; tgt = auto_tgt;
            redirect_valid = 1; redirect_pc = tgt;
            redir_hit = 1; auto_redir = 0;
            #1;
        end
        fire = imem_req_valid && rdy;
        pop  = id_valid && drdy;
        s_req_valid = imem_req_valid; s_id_valid = id_valid; s_id_pc = id_pc;
        s_fire = fire; s_pop = pop;
        if (redir) begin
            checks++;
            if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_gating: id_valid=%b req_valid=%b, required 0 0",
                         id_valid, imem_req_valid);
            end
        end
        if (fire) begin
            checks++;
            if (imem_req_addr !== exp_req || int'(mq_addr.size()) >= FIFO_DEPTH) begin
                errors++;
                $display("FAIL req_addr: addr=%h inflight=%0d, required addr=%h inflight<%0d",
                         imem_req_addr, mq_addr.size(), exp_req, FIFO_DEPTH);
            end
        end
        if (pop) begin
            checks++;
            if (id_pc !== exp_pc || id_instr !== (exp_pc ^ K)) begin
                errors++;
                $display("FAIL deliver: pc=%h instr=%h, required pc=%h instr=%h",
                         id_pc, id_instr, exp_pc, exp_pc ^ K);
            end
            n_pop++;
        end
        @(posedge clk);
        if (rv) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (fire) begin
            d = cycle + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(d);
            n_fire++;
        end
        if (r) begin
            exp_pc = 32'h0; exp_req = 32'h0;
        end else if (redir) begin
            exp_pc = tgt & ~32'h3; exp_req = tgt & ~32'h3;
        end else begin
            if (fire) exp_req = exp_req + 32'd4;
            if (pop)  exp_pc  = exp_pc + 32'd4;
        end
        cycle++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 50 && mq_addr.size() > 0; i++) step(1, 0, 0, 0, 0);
        n_pop = 0; n_fire = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid); end
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b, required 0", id_valid); end
        checks++;
        if (id_instr !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_data: instr=%h pc=%h, required 0 0", id_instr, id_pc); end
        checks++;
        if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h, required 00000000", imem_req_addr); end
    endtask

    task automatic test_straight();
        int first_fire = -1, first_valid = -1;
        do_reset();
        lat = 1;
        for (int i = 0; i < 40 && n_pop < 4; i++) begin
            step(0, 1, 1, 0, 0);
            if (s_fire && first_fire < 0) first_fire = cycle - 1;
            if (s_id_valid && first_valid < 0) first_valid = cycle - 1;
        end
        checks++;
        if (n_pop != 4) begin errors++; $display("FAIL straight_count: pops=%0d, required 4", n_pop); end
        checks++;
        if (first_valid - first_fire != 2) begin
            errors++; $display("FAIL straight_latency: %0d cycles, required 2", first_valid - first_fire);
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat = 1;
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        checks++;
        if (n_fire != 2) begin errors++; $display("FAIL stall_fires: got %0d, required 2", n_fire); end
        checks++;
        if (s_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b, required 0", s_req_valid); end
        checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0) begin
            errors++; $display("FAIL stall_head: valid=%b pc=%h, required 1 00000000", s_id_valid, s_id_pc);
        end
        for (int i = 0; i < 30 && n_pop < 3; i++) step(0, 1, 1, 0, 0);
        checks++;
        if (n_pop < 3) begin errors++; $display("FAIL stall_release: pops=%0d, required 3", n_pop); end
    endtask

    task automatic test_redirect();
        logic [31:0] first_pc = 32'hX;
        do_reset();
        lat = 3;
        for (int i = 0; i < 10 && mq_addr.size() < 2; i++) step(0, 1, 1, 0, 0);
        checks++;
        if (mq_addr.size() != 2) begin errors++; $display("FAIL redirect_setup: inflight=%0d, required 2", mq_addr.size()); end
        step(0, 1, 1, 1, 32'h0000_0102);
        n_pop = 0;
        for (int i = 0; i < 40 && n_pop < 2; i++) begin
            step(0, 1, 1, 0, 0);
            if (s_pop && n_pop == 1) first_pc = s_id_pc;
        end
        checks++;
        if (first_pc !== 32'h0000_0100) begin errors++; $display("FAIL redirect_target: pc=%h, required 00000100", first_pc); end
    endtask

    task automatic test_redirect_collide();
        logic [31:0] first_pc = 32'hX;
        do_reset();
        lat = 1;
        auto_tgt = 32'h0000_4000 + ($urandom_range(0, 255) << 2) + 32'd2;
        auto_redir = 1; redir_hit = 0;
        for (int i = 0; i < 40 && !redir_hit; i++) step(0, 1, 1, 0, 0);
        auto_redir = 0;
        checks++;
        if (!redir_hit) begin errors++; $display("FAIL collide_setup: no collision cycle found within 40 cycles"); end
        n_pop = 0;
        for (int i = 0; i < 40 && n_pop < 3; i++) begin
            step(0, 1, 1, 0, 0);
            if (s_pop && n_pop == 1) first_pc = s_id_pc;
        end
        checks++;
        if (first_pc !== (auto_tgt & ~32'h3)) begin
            errors++; $display("FAIL collide_target: pc=%h, required %h", first_pc, auto_tgt & ~32'h3);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wexp [3];
        int wn = 0;
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
        do_reset();
        for (int i = 0; i < 30 && wn < 3; i++) begin
            step(0, 0, 0, 0, 0);
            if (w_id_valid) begin
                checks++;
                if (w_id_pc !== wexp[wn] || w_id_instr !== (wexp[wn] ^ K)) begin
                    errors++;
                    $display("FAIL wrap_pc%0d: pc=%h instr=%h, required pc=%h instr=%h",
                             wn, w_id_pc, w_id_instr, wexp[wn], wexp[wn] ^ K);
                end
                wn++;
            end
        end
        checks++;
        if (wn != 3) begin errors++; $display("FAIL wrap_count: got %0d, required 3", wn); end
    endtask

    task automatic test_midflight_reset();
        bit leaked = 0;
        do_reset();
        lat = 4;
        for (int i = 0; i < 10 && mq_addr.size() < 2; i++) step(0, 1, 0, 0, 0);
        checks++;
        if (mq_addr.size() != 2) begin errors++; $display("FAIL midreset_setup: inflight=%0d, required 2", mq_addr.size()); end
        step(1, 0, 0, 0, 0);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: req_valid=%b id_valid=%b instr=%h pc=%h, required 0 0 0 0",
                     imem_req_valid, id_valid, id_instr, id_pc);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 0);
            if (s_id_valid) leaked = 1;
        end
        checks++;
        if (leaked || mq_addr.size() != 0) begin
            errors++; $display("FAIL midreset_late: leaked=%0d inflight=%0d, required 0 0", leaked, mq_addr.size());
        end
        n_pop = 0;
        for (int i = 0; i < 30 && n_pop < 2; i++) step(0, 1, 1, 0, 0);
        checks++;
        if (n_pop < 2) begin errors++; $display("FAIL midreset_resume: pops=%0d, required 2", n_pop); end
    endtask

    task automatic test_random();
        bit redir;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            lat   = $urandom_range(1, 4);
            redir = (i % 97 == 3) || (i % 97 == 4) || ($urandom % 25 == 0);
            step(0, ($urandom % 4) != 0, ($urandom % 3) != 0, redir, $urandom);
        end
        checks++;
        if (n_pop < 50) begin errors++; $display("FAIL random_progress: pops=%0d, required >= 50", n_pop); end
    endtask

    initial begin
        rst = 1; imem_req_ready = 0; id_ready = 0; redirect_valid = 0;
        redirect_pc = '0; imem_resp_valid = 0; imem_resp_data = '0;
        exp_pc = '0; exp_req = '0; auto_tgt = '0;
        @(negedge clk);
        test_reset();
        test_straight();
        test_stall();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        test_midflight_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
